// File: rtl/bru_redirect_ctrl.sv
// Front-end redirect sequencer: captures one branch/jump or trap decision from EX
// and holds the PC redirect towards fetch until it is accepted.
module bru_redirect_ctrl #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ex_valid,
  input  logic              ex_br_e,
  input  logic [ADDR_W-1:0] ex_br_addr,
  input  logic              ex_stall,
  input  logic              trap_valid,
  input  logic [ADDR_W-1:0] trap_addr,
  input  logic              if_ready,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_addr,
  output logic              redirect_misalign,
  output logic              flush_if,
  output logic              flush_id,
  output logic [CNT_W-1:0]  br_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic                is_trap;
  logic                br_held;
  logic [CNT_W-1:0]    cnt_q;

  logic                pend;
  logic                br_cap;
  logic                tr_cap;
  logic                br_held_n;

  // Handshake: redirect_valid stays high with a stable redirect_addr until a
  // cycle where if_ready is also high; that cycle completes the transfer. A trap
  // arriving in that same cycle replaces the target and restarts the handshake.
  assign pend   = (state == PEND);
  assign tr_cap = trap_valid;
  assign br_cap = ~pend & ex_valid & ex_br_e & ~br_held & ~trap_valid;

  // A branch stays held only while EX keeps stalling it and no trap kills it.
  assign br_held_n = ~tr_cap & ex_stall & (br_cap | br_held);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      addr_q  <= '0;
      is_trap <= 1'b0;
      br_held <= 1'b0;
      cnt_q   <= '0;
    end else begin
      br_held <= br_held_n;
      if (tr_cap) begin
        addr_q  <= trap_addr;
        is_trap <= 1'b1;
        state   <= PEND;
      end else if (br_cap) begin
        addr_q  <= ex_br_addr;
        is_trap <= 1'b0;
        cnt_q   <= cnt_q + 1'b1;
        state   <= PEND;
      end else if (pend && if_ready) begin
        state   <= IDLE;
      end
    end
  end

  // Flush outputs depend on live EX/trap inputs, so they are gated by reset.
  always_comb begin
    redirect_valid    = 1'b0;
    redirect_misalign = 1'b0;
    flush_if          = 1'b0;
    flush_id          = 1'b0;
    if (resetn) begin
      redirect_valid    = pend;
      redirect_misalign = pend & (addr_q[1:0] != 2'b00);
      flush_if          = br_cap | tr_cap | pend;
      flush_id          = tr_cap | (pend & is_trap) | ((br_cap | pend) & ~br_held_n);
    end
  end

  assign redirect_addr = addr_q;
  assign br_cnt        = cnt_q;

endmodule

// File: doc/bru_redirect_ctrl.md
# bru_redirect_ctrl

Sequences the branch unit's decision into a clean front-end redirect. It sits between the EX stage (bru outputs `br_e`/`br_addr`) and the IF/ID stages. A taken branch, jal, jalr or a trap is captured once, and the PC redirect is held until fetch accepts it. The controller flushes wrong-path instructions and makes sure a branch stalled in EX neither fires twice nor gets killed. Trap redirects win arbitration over branch redirects.

## Interface
- ADDR_W, 64, PC and target width
- CNT_W, 32, taken-redirect counter width

- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX holds a valid instruction
- ex_br_e  in  1  bru jump decision for the EX instruction
- ex_br_addr  in  ADDR_W  bru jump target
- ex_stall  in  1  EX will not advance at the next edge
- trap_valid  in  1  single-cycle trap redirect request
- trap_addr  in  ADDR_W  trap vector
- if_ready  in  1  fetch accepts the redirect this cycle
- redirect_valid  out  1  redirect request to fetch
- redirect_addr  out  ADDR_W  redirect target
- redirect_misalign  out  1  redirect_addr[1:0] != 0
- flush_if  out  1  clear the IF/ID register at the next edge
- flush_id  out  1  clear the ID/EX register at the next edge
- br_cnt  out  CNT_W  count of captured branch redirects

## Operation
- States are IDLE and PEND, plus three registers:
  - `addr_q` holds the redirect target.
  - `br_held` is set while the captured branch is still sitting in EX.
  - `is_trap` marks that the pending redirect is a trap.
- br_cap = state==IDLE & ex_valid & ex_br_e & ~br_held & ~trap_valid.
- tr_cap = trap_valid, accepted in any state.
- IDLE transitions:
  - On tr_cap: addr_q <= trap_addr, is_trap <= 1, go to PEND.
  - On br_cap: addr_q <= ex_br_addr, is_trap <= 0, br_held <= ex_stall, br_cnt += 1, go to PEND.
- PEND transitions:
  - On tr_cap: addr_q <= trap_addr, is_trap <= 1, stay in PEND. A trap overrides a pending branch and restarts the handshake, even when if_ready is high in the same cycle.
  - Else on if_ready: go to IDLE.
  - Branch captures are ignored while in PEND.
- redirect_valid = state==PEND.
- redirect_addr = addr_q.
- redirect_misalign = state==PEND & addr_q[1:0] != 0. This is informational; the trap logic consumes it.
- flush_if = br_cap | tr_cap | state==PEND.
- flush_id = tr_cap | (state==PEND & is_trap) | ((br_cap | state==PEND) & ~br_held_n).
  - br_held_n is the value br_held takes at the next edge.
  - This rule keeps a stalled branch (jal/jalr must still write rd) alive in ID/EX. Once EX advances, ID/EX loads a bubble because IF/ID was flushed.
- br_held is cleared on any cycle where ex_stall==0 or tr_cap. While br_held==1, no new branch capture occurs, so a stalled branch never fires twice.
- br_cnt wraps modulo 2^CNT_W. Trap captures are not counted.
- Only one redirect is outstanding at a time. The branch path is not buffered: while in PEND, EX holds only wrong-path or held instructions, so ignoring them is correct.

## Timing
- Reset (resetn low, asynchronous): state IDLE, addr_q 0, is_trap 0, br_held 0, br_cnt 0.
  - redirect_valid, redirect_misalign, flush_if and flush_id are forced to 0 while resetn is low.
  - redirect_addr = 0.
- Capture happens at the edge ending cycle N. flush_if/flush_id are combinational in cycle N. redirect_valid rises in N+1.
- The handshake completes in the cycle where redirect_valid & if_ready are both high. redirect_valid falls the following cycle.
- Minimum redirect occupancy is 1 cycle, which requires if_ready=1 in N+1. Back-to-back branch redirects occur no sooner than 2 cycles apart.
- Simultaneous trap_valid and branch: the trap wins, the branch is dropped, and br_cnt is unchanged.
- If resetn is asserted mid-PEND, the redirect is abandoned and no redirect_valid is seen after reset release.

## Test plan
- Unstalled branch: ex_valid=1, ex_br_e=1, ex_br_addr=0x8000_0100, ex_stall=0, if_ready=1.
  - Cycle N: flush_if=flush_id=1.
  - Cycle N+1: redirect_valid=1, addr=0x8000_0100.
  - Cycle N+2: redirect_valid=0, br_cnt=1.
- Stalled jal: ex_stall=1 for 3 cycles with ex_br_e held high.
  - Exactly one capture, br_cnt=1.
  - flush_id=0 while br_held; flush_if=1 throughout PEND.
  - Once ex_stall drops, the same instruction is never captured again.
- Fetch backpressure: if_ready=0 for 4 cycles.
  - redirect_valid stays high with redirect_addr constant.
  - Handshake completes on the first cycle with if_ready=1.
- Trap override: trap_valid with trap_addr=0x8000_0004 arrives while PEND holds branch target 0x8000_0200 and if_ready=1 in the same cycle.
  - State remains PEND with addr 0x8000_0004 and flush_id=1.
  - br_cnt is not incremented for the trap.
- Misaligned jalr target 0x8000_0102: redirect_misalign=1 during PEND. Counter wrap: with br_cnt preset to 0xFFFF_FFFF, one branch yields 0.
- Reset asserted mid-PEND: all outputs go to 0 asynchronously. After release, state is IDLE and br_cnt=0.
